// File: rtl/cmd_arbiter.sv
// cmd_arbiter
//
// Merges commands from several input front-ends (buttons, switch edges, UART
// decoder, tick generators) into one queue for the game state machine.
// Each source owns a one-entry holding register so simultaneous events are
// never overwritten. Occupied holding registers are granted round-robin, one
// per cycle, into a FIFO drained by a valid/ready handshake. Repeatable codes
// are coalesced against the FIFO tail, held keys auto-repeat, and every lost
// command is counted in a saturating drop counter.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous clear of FIFO, holding registers, repeat state, RR pointer
//   src_valid  per-source command strobe
//   src_cmd    per-source command code, source i at [i*CMD_W +: CMD_W]; 0 = none
//   src_hold   per-source "key still held", enables auto-repeat
//   out_valid  FIFO non-empty
//   out_cmd    FIFO head entry, 0 when empty
//   out_ready  consumer pops the head when out_valid && out_ready
//   level      current FIFO occupancy
//   drop_cnt   saturating count of lost commands

module cmd_arbiter #(
  parameter int unsigned             N_SRC         = 4,
  parameter int unsigned             CMD_W         = 4,
  parameter int unsigned             DEPTH         = 8,
  parameter logic [2**CMD_W-1:0]     COALESCE_MASK = '0,
  parameter int unsigned             REPEAT_DLY    = 25_000_000,
  parameter int unsigned             REPEAT_PER    = 5_000_000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*CMD_W-1:0]     src_cmd,
  input  logic [N_SRC-1:0]           src_hold,
  output logic                       out_valid,
  output logic [CMD_W-1:0]           out_cmd,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CW     = (RepMax > 2) ? $clog2(RepMax) : 1;

  // The counter is loaded with (delay - 1) so that the injection happens on
  // the edge exactly REPEAT_DLY / REPEAT_PER cycles after the load edge.
  localparam logic [CW-1:0] DlyLoad = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PerLoad = CW'(REPEAT_PER - 1);

  // Holding registers
  logic [N_SRC-1:0] hold_valid_q, hold_valid_d;
  logic [CMD_W-1:0] hold_cmd_q [N_SRC];
  logic [CMD_W-1:0] hold_cmd_d [N_SRC];

  // Auto-repeat state
  logic [N_SRC-1:0] rep_armed_q, rep_armed_d;
  logic [CW-1:0]    rep_cnt_q [N_SRC];
  logic [CW-1:0]    rep_cnt_d [N_SRC];
  logic [CMD_W-1:0] rep_cmd_q [N_SRC];
  logic [CMD_W-1:0] rep_cmd_d [N_SRC];

  // Arbitration
  logic [PW-1:0]    rr_q, rr_d;
  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    cand;
  logic [N_SRC-1:0] gnt_vec;
  logic [CMD_W-1:0] gnt_cmd;

  // Capture decode
  logic [CMD_W-1:0] in_cmd [N_SRC];
  logic [N_SRC-1:0] new_cmd;
  logic [N_SRC-1:0] slot_free;
  logic [N_SRC-1:0] cap_drop;

  // FIFO
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [AW:0]      level_q, level_d;
  logic             level_nz, fifo_full;
  logic             pop, push, coalesce, fifo_drop;
  logic [CMD_W-1:0] tail_cmd;

  // Drop accounting
  logic [8:0]       drop_inc;
  logic [9:0]       drop_sum;
  logic [7:0]       drop_q, drop_d;

  // ---------------------------------------------------------------------------
  // Round-robin grant: first occupied holding register at or after rr_q.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      cand = PW'((32'(rr_q) + off) % N_SRC);
      if (!gnt_any && hold_valid_q[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vec          = '0;
    gnt_vec[gnt_idx] = gnt_any;
    gnt_cmd          = hold_cmd_q[gnt_idx];
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) begin
      rr_d = (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Capture and auto-repeat, per source.
  // A slot is free if empty or being granted this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      in_cmd[i]    = src_cmd[i*CMD_W +: CMD_W];
      new_cmd[i]   = src_valid[i] && (in_cmd[i] != '0);
      slot_free[i] = !hold_valid_q[i] || gnt_vec[i];
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q & ~gnt_vec;
    hold_cmd_d   = hold_cmd_q;
    rep_armed_d  = rep_armed_q;
    rep_cnt_d    = rep_cnt_q;
    rep_cmd_d    = rep_cmd_q;
    cap_drop     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (new_cmd[i] && slot_free[i]) begin
        // Accepted strobe; also overrides any injection due this cycle.
        hold_valid_d[i] = 1'b1;
        hold_cmd_d[i]   = in_cmd[i];
        rep_armed_d[i]  = src_hold[i];
        rep_cnt_d[i]    = DlyLoad;
        rep_cmd_d[i]    = in_cmd[i];
      end else begin
        if (new_cmd[i]) begin
          cap_drop[i] = 1'b1;
        end
        if (!src_hold[i]) begin
          rep_armed_d[i] = 1'b0;
        end else if (rep_armed_q[i]) begin
          if (rep_cnt_q[i] != '0) begin
            rep_cnt_d[i] = rep_cnt_q[i] - CW'(1);
          end else if (slot_free[i]) begin
            hold_valid_d[i] = 1'b1;
            hold_cmd_d[i]   = rep_cmd_q[i];
            rep_cnt_d[i]    = PerLoad;
          end
          // Otherwise the counter stalls at zero until the slot frees up.
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO enqueue / dequeue decisions.
  // ---------------------------------------------------------------------------
  always_comb begin
    level_nz  = (level_q != '0);
    fifo_full = (level_q == (AW+1)'(DEPTH));
    pop       = level_nz && out_ready;
    tail_ptr  = wr_ptr_q - AW'(1);
    tail_cmd  = mem_q[tail_ptr];
    // When the only entry is leaving this cycle there is nothing left to
    // merge into, so the command is written instead.
    coalesce  = gnt_any && COALESCE_MASK[gnt_cmd] && level_nz &&
                (tail_cmd == gnt_cmd) && !((level_q == (AW+1)'(1)) && pop);
    fifo_drop = gnt_any && !coalesce && fifo_full && !pop;
    push      = gnt_any && !coalesce && !fifo_drop;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: capture drops on any source plus a FIFO-full drop, saturating.
  // ---------------------------------------------------------------------------
  always_comb begin
    drop_inc = 9'(fifo_drop);
    for (int i = 0; i < N_SRC; i++) begin
      drop_inc = drop_inc + 9'(cap_drop[i]);
    end
    drop_sum = 10'(drop_q) + 10'(drop_inc);
    drop_d   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
      rr_q         <= '0;
      hold_valid_q <= '0;
      rep_armed_q  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold_cmd_q[i] <= '0;
        rep_cnt_q[i]  <= '0;
        rep_cmd_q[i]  <= '0;
      end
    end else if (flush) begin
      // drop_q deliberately survives a flush.
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rr_q         <= '0;
      hold_valid_q <= '0;
      rep_armed_q  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        hold_cmd_q[i] <= '0;
        rep_cnt_q[i]  <= '0;
        rep_cmd_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q      <= level_d;
      drop_q       <= drop_d;
      rr_q         <= rr_d;
      hold_valid_q <= hold_valid_d;
      hold_cmd_q   <= hold_cmd_d;
      rep_armed_q  <= rep_armed_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_cmd_q    <= rep_cmd_d;
    end
  end

  // Storage needs no reset: out_cmd is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= gnt_cmd;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = level_nz;
  assign out_cmd   = level_nz ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [3:0]  src_valid;
  logic [15:0] src_cmd;
  logic [3:0]  src_hold;
  logic        out_valid;
  logic [3:0]  out_cmd;
  logic        out_ready;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  cmd_arbiter #(
    .N_SRC        (4),
    .CMD_W        (4),
    .DEPTH        (8),
    .COALESCE_MASK(16'h0008),
    .REPEAT_DLY   (10),
    .REPEAT_PER   (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .src_valid(src_valid),
    .src_cmd  (src_cmd),
    .src_hold (src_hold),
    .out_valid(out_valid),
    .out_cmd  (out_cmd),
    .out_ready(out_ready),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] cmd;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_cmd;
    logic [3:0]  exp_level;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] v, input logic [15:0] c, input logic r,
                     input logic ev, input logic [3:0] ec, input logic [3:0] el,
                     input logic [7:0] ed);
    vec_t t;
    t.valid = v; t.cmd = c; t.ready = r;
    t.exp_valid = ev; t.exp_cmd = ec; t.exp_level = el; t.exp_drop = ed;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] v, input logic [15:0] c, input logic [3:0] h,
                       input logic r, input logic f);
    src_valid = v; src_cmd = c; src_hold = h; out_ready = r; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          rep_hits[6] = '{1, 11, 15, 19, 23, 27};
  logic [3:0]  ovf_codes[10] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

  initial begin
    reset_n = 1'b0;
    apply(4'b0, 16'h0, 4'b0, 1'b0, 1'b0);

    // Basic latency, simultaneous strobes, RR order, zero code, capture drop.
    add(4'b1000, 16'h2000, 0, 0, 0, 0, 0);
    add(4'b0000, 16'h0000, 0, 1, 2, 1, 0);
    add(4'b0000, 16'h0000, 1, 0, 0, 0, 0);
    add(4'b1111, 16'h8765, 0, 0, 0, 0, 0);
    add(4'b0000, 16'h0000, 0, 1, 5, 1, 0);
    add(4'b0000, 16'h0000, 0, 1, 5, 2, 0);
    add(4'b0000, 16'h0000, 0, 1, 5, 3, 0);
    add(4'b0000, 16'h0000, 0, 1, 5, 4, 0);
    add(4'b0000, 16'h0000, 1, 1, 6, 3, 0);
    add(4'b0000, 16'h0000, 1, 1, 7, 2, 0);
    add(4'b0000, 16'h0000, 1, 1, 8, 1, 0);
    add(4'b0000, 16'h0000, 1, 0, 0, 0, 0);
    add(4'b0010, 16'h0010, 0, 0, 0, 0, 0);
    add(4'b0000, 16'h0000, 0, 1, 1, 1, 0);
    add(4'b0000, 16'h0000, 1, 0, 0, 0, 0);
    add(4'b1111, 16'h8765, 0, 0, 0, 0, 0);
    add(4'b0000, 16'h0000, 0, 1, 7, 1, 0);
    add(4'b0000, 16'h0000, 0, 1, 7, 2, 0);
    add(4'b0000, 16'h0000, 0, 1, 7, 3, 0);
    add(4'b0000, 16'h0000, 0, 1, 7, 4, 0);
    add(4'b0000, 16'h0000, 1, 1, 8, 3, 0);
    add(4'b0000, 16'h0000, 1, 1, 5, 2, 0);
    add(4'b0000, 16'h0000, 1, 1, 6, 1, 0);
    add(4'b0000, 16'h0000, 1, 0, 0, 0, 0);
    add(4'b0001, 16'h0000, 0, 0, 0, 0, 0);
    add(4'b0000, 16'h0000, 0, 0, 0, 0, 0);
    add(4'b0011, 16'h0021, 0, 0, 0, 0, 0);
    add(4'b0011, 16'h0054, 0, 1, 1, 1, 1);
    add(4'b0000, 16'h0000, 0, 1, 1, 2, 1);
    add(4'b0000, 16'h0000, 0, 1, 1, 3, 1);
    add(4'b0000, 16'h0000, 1, 1, 2, 2, 1);
    add(4'b0000, 16'h0000, 1, 1, 4, 1, 1);
    add(4'b0000, 16'h0000, 1, 0, 0, 0, 1);

    // Reset state
    #12;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_cmd",   32'(out_cmd),   0);
    chk("reset level",     32'(level),     0);
    chk("reset drop_cnt",  32'(drop_cnt),  0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    foreach (vq[i]) begin
      apply(vq[i].valid, vq[i].cmd, 4'b0, vq[i].ready, 1'b0);
      tick();
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vq[i].exp_valid));
      chk($sformatf("row%0d out_cmd", i),   32'(out_cmd),   32'(vq[i].exp_cmd));
      chk($sformatf("row%0d level", i),     32'(level),     32'(vq[i].exp_level));
      chk($sformatf("row%0d drop_cnt", i),  32'(drop_cnt),  32'(vq[i].exp_drop));
    end

    // Coalesce: code 3 merges into tail, code 4 does not.
    apply(4'b0010, 16'h0030, 4'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    apply(4'b0000, 16'h0000, 4'b0, 1'b0, 1'b0);
    tick();
    chk("coalesce level",    32'(level),    1);
    chk("coalesce out_cmd",  32'(out_cmd),  3);
    chk("coalesce drop_cnt", 32'(drop_cnt), 1);
    apply(4'b0010, 16'h0040, 4'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    apply(4'b0000, 16'h0000, 4'b0, 1'b0, 1'b0);
    tick();
    chk("no-coalesce level", 32'(level), 4);
    apply(4'b0010, 16'h0050, 4'b0, 1'b0, 1'b0);
    tick();
    apply(4'b0000, 16'h0000, 4'b0, 1'b0, 1'b0);
    tick();
    chk("pre-reset level", 32'(level), 5);

    // Asynchronous reset mid-traffic, checked away from any clock edge.
    reset_n = 1'b0;
    #2;
    chk("async reset level",     32'(level),     0);
    chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset out_cmd",   32'(out_cmd),   0);
    chk("async reset drop_cnt",  32'(drop_cnt),  0);
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Coalescable code against a tail that is popped the same cycle: written.
    apply(4'b0010, 16'h0030, 4'b0, 1'b0, 1'b0);
    tick();
    apply(4'b0000, 16'h0000, 4'b0, 1'b0, 1'b0);
    tick();
    apply(4'b0010, 16'h0030, 4'b0, 1'b0, 1'b0);
    tick();
    apply(4'b0000, 16'h0000, 4'b0, 1'b1, 1'b0);
    tick();
    chk("coalesce-pop level",     32'(level),     1);
    chk("coalesce-pop out_valid", 32'(out_valid), 1);
    chk("coalesce-pop out_cmd",   32'(out_cmd),   3);
    tick();
    chk("coalesce-pop drained", 32'(level), 0);
    apply(4'b0000, 16'h0000, 4'b0, 1'b0, 1'b0);

    // Overflow: 10 distinct codes into an 8-deep FIFO with no pops.
    for (int k = 0; k < 10; k++) begin
      apply(4'b0001, {12'h000, ovf_codes[k]}, 4'b0, 1'b0, 1'b0);
      tick();
      apply(4'b0000, 16'h0000, 4'b0, 1'b0, 1'b0);
      tick();
    end
    chk("overflow level",    32'(level),    8);
    chk("overflow drop_cnt", 32'(drop_cnt), 2);
    chk("overflow head",     32'(out_cmd),  1);
    apply(4'b0001, 16'h000C, 4'b0, 1'b0, 1'b0);
    tick();
    apply(4'b0000, 16'h0000, 4'b0, 1'b1, 1'b0);
    tick();
    chk("full push+pop level", 32'(level),    8);
    chk("full push+pop drop",  32'(drop_cnt), 2);
    chk("full push+pop head",  32'(out_cmd),  2);

    // Flush with level 6 and occupied holding registers.
    tick(); tick();
    chk("pre-flush level", 32'(level),   6);
    chk("pre-flush head",  32'(out_cmd), 5);
    apply(4'b1111, 16'h4321, 4'b0, 1'b0, 1'b0);
    tick();
    chk("holds loaded level", 32'(level), 6);
    apply(4'b1111, 16'hDCBA, 4'b0, 1'b1, 1'b1);
    tick();
    chk("flush level",     32'(level),     0);
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush out_cmd",   32'(out_cmd),   0);
    chk("flush drop_cnt",  32'(drop_cnt),  2);
    apply(4'b0000, 16'h0000, 4'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("post-flush level",     32'(level),     0);
    chk("post-flush out_valid", 32'(out_valid), 0);

    // Auto-repeat: src 2 code 9, held for 30 sampled edges, consumer always ready.
    apply(4'b0100, 16'h0900, 4'b0100, 1'b1, 1'b0);
    tick();
    apply(4'b0000, 16'h0000, 4'b0100, 1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      logic exp_hit;
      tick();
      exp_hit = 1'b0;
      foreach (rep_hits[j]) if (rep_hits[j] == k) exp_hit = 1'b1;
      chk($sformatf("repeat k=%0d out_valid", k), 32'(out_valid), 32'(exp_hit));
      if (exp_hit) chk($sformatf("repeat k=%0d out_cmd", k), 32'(out_cmd), 9);
      if (k == 29) src_hold = 4'b0000;
    end
    chk("repeat drop_cnt", 32'(drop_cnt), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
